// File: rtl/ysyx_23060208_lsu_pkg.sv
// rtl/ysyx_23060208_lsu_pkg.sv - shared LSU state, error, size and AXI response codes
package ysyx_23060208_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_AR,
        ST_RD_R,
        ST_WR_AWW,
        ST_WR_B,
        ST_RESP
    } lsu_state_e;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_BUS      = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_MISALIGN = 2'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    // A dword request on a 32-bit bus degrades to a word access.
    function automatic logic [1:0] eff_size(input logic [1:0] size, input int data_width);
        return (size == SZ_D && data_width == 32) ? SZ_W : size;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] low, input logic [1:0] size);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return low[0];
            SZ_W:    return |low[1:0];
            default: return |low;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060208_lsu_if.sv
// rtl/ysyx_23060208_lsu_if.sv - AXI4-Lite data-side bus between LSU and arbiter
interface ysyx_23060208_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic                  m_awvalid;
    logic                  m_awready;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [STRB_W-1:0]     m_wstrb;
    logic                  m_wvalid;
    logic                  m_wready;
    logic [1:0]            m_bresp;
    logic                  m_bvalid;
    logic                  m_bready;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic                  m_arvalid;
    logic                  m_arready;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rvalid;
    logic                  m_rready;

    modport master (
        output m_awaddr, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input m_bresp, m_bvalid, output m_bready,
        output m_araddr, m_arvalid, input m_arready,
        input m_rdata, m_rresp, m_rvalid, output m_rready
    );

    modport slave (
        input m_awaddr, m_awvalid, output m_awready,
        input m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready,
        input m_araddr, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready
    );

endinterface

// File: rtl/ysyx_23060208_lsu_lane.sv
// rtl/ysyx_23060208_lsu_lane.sv - byte-lane steering: store strobe/shift, load extract/extend
module ysyx_23060208_lsu_lane
    import ysyx_23060208_lsu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int OFF_W      = $clog2(STRB_W)
) (
    input  logic [1:0]            size,
    input  logic                  ld_unsigned,
    input  logic [OFF_W-1:0]      off,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic [STRB_W-1:0]     wstrb,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [1:0]            sz;
    logic [DATA_WIDTH-1:0] raw;
    logic [DATA_WIDTH-1:0] keep;
    logic                  sgn;

    always_comb begin
        sz    = eff_size(size, DATA_WIDTH);
        // Lanes shifted past STRB_W fall off the top: unaligned accesses truncate.
        wstrb = ~({STRB_W{1'b1}} << (1 << sz)) << off;
        wdata = st_data << {off, 3'b000};
        raw   = bus_rdata >> {off, 3'b000};
        keep  = ~({DATA_WIDTH{1'b1}} << (8 << sz));
        case (sz)
            SZ_B:    sgn = raw[7];
            SZ_H:    sgn = raw[15];
            SZ_W:    sgn = raw[31];
            default: sgn = raw[DATA_WIDTH-1];
        endcase
        sgn     = sgn & ~ld_unsigned;
        ld_data = (raw & keep) | ({DATA_WIDTH{sgn}} & ~keep);
    end

endmodule

// File: rtl/ysyx_23060208_lsu.sv
// rtl/ysyx_23060208_lsu.sv - AXI4-Lite load/store unit, one op in flight
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with err=3 and no bus traffic.
module ysyx_23060208_lsu
    import ysyx_23060208_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [REG_WIDTH-1:0]  req_rd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [REG_WIDTH-1:0]  resp_rd,
    output logic [1:0]            resp_err,
    ysyx_23060208_lsu_if.master   m
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    lsu_state_e            state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            op_size;
    logic                  op_unsigned;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [REG_WIDTH-1:0]  op_rd;
    logic                  aw_done, w_done;
    logic                  aw_fire, w_fire;
    logic                  to_hit, bus_wait, trap;
    logic                  resp_load;
    logic [1:0]            resp_err_nxt;
    logic [DATA_WIDTH-1:0] resp_rdata_nxt;
    logic [REG_WIDTH-1:0]  resp_rd_nxt;
    logic [STRB_W-1:0]     lane_wstrb;
    logic [DATA_WIDTH-1:0] lane_wdata, lane_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(req_addr[2:0], eff_size(req_size, DATA_WIDTH));
`else
    assign trap = 1'b0;
`endif

    ysyx_23060208_lsu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .size        (op_size),
        .ld_unsigned (op_unsigned),
        .off         (op_addr[OFF_W-1:0]),
        .st_data     (op_wdata),
        .bus_rdata   (m.m_rdata),
        .wstrb       (lane_wstrb),
        .wdata       (lane_wdata),
        .ld_data     (lane_rdata)
    );

    assign m.m_araddr  = op_addr;
    assign m.m_arvalid = (state == ST_RD_AR);
    assign m.m_rready  = (state == ST_RD_R);
    assign m.m_awaddr  = op_addr;
    assign m.m_awvalid = (state == ST_WR_AWW) && !aw_done;
    assign m.m_wvalid  = (state == ST_WR_AWW) && !w_done;
    assign m.m_wdata   = (state == ST_WR_AWW) ? lane_wdata : '0;
    assign m.m_wstrb   = (state == ST_WR_AWW) ? lane_wstrb : '0;
    assign m.m_bready  = (state == ST_WR_B);

    assign aw_fire  = m.m_awvalid && m.m_awready;
    assign w_fire   = m.m_wvalid && m.m_wready;
    assign bus_wait = (state == ST_RD_AR) || (state == ST_RD_R) ||
                      (state == ST_WR_AWW) || (state == ST_WR_B);
    assign to_hit   = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Bus handshakes are tested before the timeout so a same-cycle completion wins.
    always_comb begin
        state_nxt      = state;
        resp_load      = 1'b0;
        resp_err_nxt   = ERR_OK;
        resp_rdata_nxt = '0;
        resp_rd_nxt    = op_rd;
        req_ready      = (state == ST_IDLE);
        resp_valid     = (state == ST_RESP);
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (trap) begin
                        state_nxt    = ST_RESP;
                        resp_load    = 1'b1;
                        resp_err_nxt = ERR_MISALIGN;
                        resp_rd_nxt  = req_we ? '0 : req_rd;
                    end else begin
                        state_nxt = req_we ? ST_WR_AWW : ST_RD_AR;
                    end
                end
            end
            ST_RD_AR: begin
                if (m.m_arready) begin
                    state_nxt = ST_RD_R;
                end else if (to_hit) begin
                    state_nxt    = ST_RESP;
                    resp_load    = 1'b1;
                    resp_err_nxt = ERR_TIMEOUT;
                end
            end
            ST_RD_R: begin
                if (m.m_rvalid) begin
                    state_nxt = ST_RESP;
                    resp_load = 1'b1;
                    if (m.m_rresp != AXI_OKAY) resp_err_nxt   = ERR_BUS;
                    else                       resp_rdata_nxt = lane_rdata;
                end else if (to_hit) begin
                    state_nxt    = ST_RESP;
                    resp_load    = 1'b1;
                    resp_err_nxt = ERR_TIMEOUT;
                end
            end
            ST_WR_AWW: begin
                if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                    state_nxt = ST_WR_B;
                end else if (to_hit) begin
                    state_nxt    = ST_RESP;
                    resp_load    = 1'b1;
                    resp_err_nxt = ERR_TIMEOUT;
                end
            end
            ST_WR_B: begin
                if (m.m_bvalid) begin
                    state_nxt    = ST_RESP;
                    resp_load    = 1'b1;
                    resp_err_nxt = (m.m_bresp != AXI_OKAY) ? ERR_BUS : ERR_OK;
                end else if (to_hit) begin
                    state_nxt    = ST_RESP;
                    resp_load    = 1'b1;
                    resp_err_nxt = ERR_TIMEOUT;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            op_size     <= SZ_B;
            op_unsigned <= 1'b0;
            op_addr     <= '0;
            op_wdata    <= '0;
            op_rd       <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            resp_rdata  <= '0;
            resp_rd     <= '0;
            resp_err    <= ERR_OK;
        end else begin
            cnt <= (state_nxt != state || !bus_wait) ? '0 : cnt + 1'b1;
            if (req_ready && req_valid) begin
                op_size     <= req_size;
                op_unsigned <= req_unsigned;
                op_addr     <= req_addr;
                op_wdata    <= req_wdata;
                op_rd       <= req_we ? '0 : req_rd;
            end
            if (state == ST_WR_AWW) begin
                if (aw_fire) aw_done <= 1'b1;
                if (w_fire)  w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (resp_load) begin
                resp_rdata <= resp_rdata_nxt;
                resp_rd    <= resp_rd_nxt;
                resp_err   <= resp_err_nxt;
            end
        end
    end

endmodule
